qmult_seq: RTL and testbench
============================

// Module: qmult_seq
// PURPOSE
//  Sequential sign-magnitude fixed-point multiplier in the inversek2j datapath: a*b in Q(N-1-Q).Q.
//  Sits directly upstream of the qadd sign-magnitude adder and produces its operands
//  (products of joint lengths and sin/cos terms). Uses the same number format as qadd:
//  bit N-1 = sign, bits N-2:0 = magnitude, no negative zero.
//  Iterative shift-add core: one partial product per cycle, start/done handshake.
// PARAMETERS
//  Q  15  number of fractional bits
//  N  32  total word width including sign bit (N >= Q+2)
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  synchronous, active-low reset
//  i_start   in   1  request; sampled only in IDLE
//  i_a       in   N  multiplicand, sign-magnitude; latched when i_start is accepted
//  i_b       in   N  multiplier, sign-magnitude; latched when i_start is accepted
//  o_busy    out  1  high while state != IDLE
//  o_done    out  1  one-cycle pulse; o_result and o_ovr are valid in that cycle
//  o_result  out  N  product, sign-magnitude; held until the next accepted start
//  o_ovr     out  1  magnitude overflow (saturated); held with o_result
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; o_busy=0, o_done=0, o_result=0, o_ovr=0; internal regs cleared.
//  Reset mid-operation: the operation is aborted, no o_done is produced, and the block is ready one cycle after rst_n=1.
//  FSM states and transitions:
//   IDLE: if i_start, latch mag_a=i_a[N-2:0], mag_b=i_b[N-2:0], sgn=i_a[N-1]^i_b[N-1];
//         clear acc (2N-2 bits) and cnt; go to CALC. Otherwise stay in IDLE.
//   CALC: each cycle, if mag_b[0] then acc += mcand; then mcand <<= 1 and mag_b >>= 1; cnt++.
//         Exactly N-1 iterations. On the last iteration (cnt==N-2), register the packed result and go to DONE.
//   DONE: o_done=1 for this cycle only; go to IDLE.
//  i_start is ignored in CALC and DONE. No queuing. Operands may change freely after acceptance.
//  Latency: o_done is high in the cycle that begins N-1 edges after the edge that sampled i_start (31 for N=32).
//   Minimum start-to-start interval is N+1 cycles.
//  Packing of the full product P = acc[2N-3:0]:
//   mag = P[Q+N-2:Q], truncated toward zero with no rounding.
//   If P[2N-3:Q+N-1] != 0: mag = all ones and o_ovr=1; otherwise o_ovr=0.
//   If mag == 0 after truncation, the sign is forced to 0 (no negative zero); otherwise the sign is sgn.
//  o_result and o_ovr update only on the DONE-entry edge; they are stable at all other times.
//  Either operand equal to +0 or -0 gives result 0x0 with o_ovr=0.
// STRUCTURE
//  Shared package: state encodings (IDLE/CALC/DONE as localparams), the sign-magnitude field helpers
//   (SGN bit index N-1, MAG range N-2:0), and the counter width clog2(N-1).
//   The same package is used by qadd.
//  One natural sub-module: qmult_pack. It is combinational and implements truncate/saturate/zero-sign
//   from acc and sgn to {mag, sign, ovr}; it is reusable by a future pipelined multiplier.
//  The FSM, counter and shift-add datapath stay in qmult_seq.
// TESTING (Q=15, N=32)
//  1) 0x0000C000 * 0x00010000 (1.5*2.0) -> o_result=0x00018000, o_ovr=0.
//     o_done exactly 31 cycles after the start edge, single-cycle pulse.
//  2) 0x8000C000 * 0x00010000 -> 0x80018000. Also 0x8000C000 * 0x80010000 -> 0x00018000.
//  3) 0x00000000 * 0x80008000 -> 0x00000000. Also 0x80000001 * 0x00000001 (truncates to 0) -> 0x00000000, not 0x80000000.
//  4) 0x7FFFFFFF * 0x7FFFFFFF -> 0x7FFFFFFF, o_ovr=1. Next operation 0x00008000*0x00008000 -> 0x00008000, o_ovr=0.
//  5) Pulse i_start in cycles 5 and 20 of a busy operation -> ignored: one o_done only, result matches the first operands.
//  6) Drive rst_n=0 for one cycle mid-CALC -> no o_done, all outputs 0.
//     A start 1 cycle after rst_n=1 completes normally (1.0*1.0 -> 0x00008000).

Source files
------------

// File: rtl/qmult_seq_pkg.sv
// qmult_seq_pkg: shared state encoding and sign-magnitude field helpers for qmult_seq/qadd
package qmult_seq_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int sgn_idx(input int n);
    return n - 1;
  endfunction
  function automatic int mag_msb(input int n);
    return n - 2;
  endfunction
  function automatic int cnt_width(input int n);
    return $clog2(n - 1);
  endfunction
endpackage

// File: rtl/qmult_pack.sv
// qmult_pack: truncate/saturate/zero-sign packing of a 2N-2 bit magnitude product
//  acc  in  2N-2  full unsigned product magnitude
//  sgn  in  1     product sign before zero fixup
//  mag  out N-1   truncated or saturated magnitude
//  sign out 1     output sign, forced to 0 when mag is zero
//  ovr  out 1     magnitude overflow
module qmult_pack import qmult_seq_pkg::*; #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [2*N-3:0]    acc,
  input  logic              sgn,
  output logic [mag_msb(N):0] mag,
  output logic              sign,
  output logic              ovr
);
  logic [2*N-3:0] shifted;
  assign shifted = acc >> Q;
  assign ovr = |shifted[2*N-3:N-1];
  assign mag = ovr ? '1 : shifted[N-2:0];
  assign sign = sgn & |mag;
endmodule

// File: rtl/qmult_seq.sv
// qmult_seq: sequential shift-add sign-magnitude fixed-point multiplier, Q fractional bits
//  clk      in  1  clock, rising edge
//  rst_n    in  1  synchronous active-low reset
//  i_start  in  1  request, sampled only when idle
//  i_a/i_b  in  N  sign-magnitude operands, latched on accepted start
//  o_busy   out 1  high while not idle
//  o_done   out 1  one-cycle pulse with result valid
//  o_result out N  sign-magnitude product, held until next done
//  o_ovr    out 1  saturation flag, held with o_result
module qmult_seq import qmult_seq_pkg::*; #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_ovr
);
  localparam int CW = cnt_width(N);
  localparam int AW = 2*N - 2;
  state_t state;
  logic [N-2:0] mag_b, pk_mag;
  logic [AW-1:0] mcand, acc, acc_next;
  logic [CW-1:0] cnt;
  logic sgn, pk_sgn, pk_ovr;
  assign acc_next = acc + (mag_b[0] ? mcand : '0);
  assign o_busy = state != IDLE;
  // packing looks at acc_next so the last partial product lands in the same edge as DONE entry
  qmult_pack #(.Q(Q), .N(N)) u_pack (
    .acc(acc_next),
    .sgn(sgn),
    .mag(pk_mag),
    .sign(pk_sgn),
    .ovr(pk_ovr)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mag_b <= '0;
      mcand <= '0;
      acc <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      o_done <= 1'b0;
      o_result <= '0;
      o_ovr <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          mcand <= AW'(i_a[mag_msb(N):0]);
          mag_b <= i_b[mag_msb(N):0];
          sgn <= i_a[sgn_idx(N)] ^ i_b[sgn_idx(N)];
          acc <= '0;
          cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_next;
          mcand <= mcand << 1;
          mag_b <= mag_b >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-2)) begin
            o_result <= {pk_sgn, pk_mag};
            o_ovr <= pk_ovr;
            o_done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qmult_seq.sv
// tb_qmult_seq: scoreboard bench for qmult_seq against an arithmetic reference model
module tb_qmult_seq;
  localparam int Q = 15;
  localparam int N = 32;
  typedef struct {
    logic [N-1:0] res;
    logic         ovr;
    int           cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [N-1:0] i_a = '0, i_b = '0;
  logic o_busy, o_done, o_ovr;
  logic [N-1:0] o_result;
  int checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t last;
  logic done_prev = 1'b0;
  qmult_seq #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_ovr(o_ovr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    longint unsigned p, m;
    p = longint'(a[N-2:0]) * longint'(b[N-2:0]);
    m = p / (64'd1 << Q);
    e.ovr = m >= (64'd1 << (N-1));
    if (e.ovr) m = (64'd1 << (N-1)) - 1;
    e.res = {(m != 0) && (a[N-1] ^ b[N-1]), m[N-2:0]};
    e.cyc = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      chk("done_single_pulse", done_prev, 0);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", o_result, e.res);
        chk("ovr", o_ovr, e.ovr);
        chk("latency", cyc, e.cyc);
      end
    end
    done_prev = o_done;
  end
  task automatic wait_idle();
    int t = 0;
    while (o_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_before_start", o_busy, 0);
  endtask
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    wait_idle();
    e = model(a, b);
    e.cyc = cyc + N;
    sb.push_back(e);
    last = e;
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
  endtask
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
    issue(a, b);
    repeat (N) @(negedge clk);
    chk("result_held", o_result, last.res);
    chk("ovr_held", o_ovr, last.ovr);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_result", o_result, 0);
    chk("rst_ovr", o_ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    op(32'h0000C000, 32'h00010000);
    op(32'h8000C000, 32'h00010000);
    op(32'h8000C000, 32'h80010000);
    op(32'h00000000, 32'h80008000);
    op(32'h80000001, 32'h00000001);
    op(32'h7FFFFFFF, 32'h7FFFFFFF);
    op(32'h00008000, 32'h00008000);
    op(32'h80000000, 32'h7FFFFFFF);
    issue(32'h00014000, 32'h80018000);
    repeat (4) @(negedge clk);
    i_a = 32'h7FFFFFFF; i_b = 32'h7FFFFFFF; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (14) @(negedge clk);
    i_a = 32'h00000001; i_b = 32'h80000001; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (N) @(negedge clk);
    chk("ignored_start_queue", sb.size(), 0);
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] a, b;
      a = $urandom & ({N{1'b1}} >> $urandom_range(0, 24));
      b = $urandom & ({N{1'b1}} >> $urandom_range(0, 24));
      a[N-1] = $urandom_range(0, 1);
      b[N-1] = $urandom_range(0, 1);
      op(a, b);
    end
    op(32'h7FFFFFFF, 32'h7FFFFFFF);
    issue(32'h00018000, 32'h00018000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    chk("abort_busy", o_busy, 0);
    chk("abort_result", o_result, 0);
    chk("abort_ovr", o_ovr, 0);
    chk("abort_done", o_done, 0);
    @(negedge clk);
    op(32'h00008000, 32'h00008000);
    repeat (N + 4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
